// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch-stage PC generator.
// Holds the PC state encoding, the redirect-source enum and the default reset vector.
package mips_pkg;

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_PEND,
      ST_DSLOT
   } pc_state_e;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_BR,
      SRC_JMP,
      SRC_EXC
   } redir_src_e;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/pc_gen_unit_if.sv
// Fetch handshake and redirect bus of the PC generator.
// The master modport is the PC generator; the slave modport is fetch plus redirect sources.
interface pc_gen_unit_if #(
   parameter int XLEN = 32
);
   logic            if_ready;
   logic            pc_valid;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus_inc;
   logic            br_taken;
   logic [XLEN-1:0] br_base;
   logic [XLEN-1:0] br_offset;
   logic            jmp_en;
   logic [XLEN-1:0] jmp_target;
   logic            exc_en;
   logic [XLEN-1:0] exc_vector;
   logic            target_misalign;

   modport master (
      input  if_ready, br_taken, br_base, br_offset, jmp_en, jmp_target, exc_en, exc_vector,
      output pc_valid, pc, pc_plus_inc, target_misalign
   );

   modport slave (
      output if_ready, br_taken, br_base, br_offset, jmp_en, jmp_target, exc_en, exc_vector,
      input  pc_valid, pc, pc_plus_inc, target_misalign
   );
endinterface

// File: rtl/pc_target_adder.sv
// Branch target adder: base + INC + (offset << 2), all modulo 2^XLEN.
module pc_target_adder #(
   parameter int XLEN = 32,
   parameter int INC  = 4
) (
   input  logic [XLEN-1:0] base,
   input  logic [XLEN-1:0] offset,
   output logic [XLEN-1:0] target
);
   // Word offset becomes a byte offset; bits shifted out of the top are dropped.
   assign target = base + XLEN'(INC) + (offset << 2);
endmodule

// File: rtl/pc_gen_unit.sv
// Registered fetch PC generator with valid/ready handshake and prioritised redirects
// (exception > jump > branch). A redirect seen while fetch stalls waits in a one-entry
// pending register. Optional MIPS delay slot behaviour is enabled by PCGEN_DELAY_SLOT_EN.
module pc_gen_unit
   import mips_pkg::*;
#(
   parameter int          XLEN         = 32,
   parameter int          INC          = 4,
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
   input  logic          clk,
   input  logic          rst_n,
   pc_gen_unit_if.master bus
);
   localparam logic [XLEN-1:0] RST_PC = XLEN'(RESET_VECTOR);
   localparam logic [XLEN-1:0] INC_X  = XLEN'(INC);

   pc_state_e       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_plus_inc_q, pc_plus_inc_d;
   logic            target_misalign_q, target_misalign_d;
   logic [XLEN-1:0] pend_target_q, pend_target_d;
   redir_src_e      pend_src_q, pend_src_d;

   logic [XLEN-1:0] br_target;
   redir_src_e      redir_src;
   logic [XLEN-1:0] redir_target;
   logic            pc_valid;
   logic            fire;
   logic            load_en;
   logic            seq_en;
   logic [XLEN-1:0] load_target;
   logic            pend_take_new;

   pc_target_adder #(.XLEN(XLEN), .INC(INC)) u_target_adder (
      .base   (bus.br_base),
      .offset (bus.br_offset),
      .target (br_target)
   );

   assign pc_valid = (state_q != ST_BOOT);
   assign fire     = pc_valid & bus.if_ready;

   // Pick the highest-priority redirect presented this cycle.
   always_comb begin
      redir_src    = SRC_NONE;
      redir_target = '0;
      if (bus.exc_en) begin
         redir_src    = SRC_EXC;
         redir_target = bus.exc_vector;
      end else if (bus.jmp_en) begin
         redir_src    = SRC_JMP;
         redir_target = bus.jmp_target;
      end else if (bus.br_taken) begin
         redir_src    = SRC_BR;
         redir_target = br_target;
      end
   end

   // Next-state, next-pc and pending-register update.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path infers a latch.
      state_d           = state_q;
      pc_d              = pc_q;
      pc_plus_inc_d     = pc_plus_inc_q;
      target_misalign_d = 1'b0;
      pend_target_d     = pend_target_q;
      pend_src_d        = pend_src_q;
      load_en           = 1'b0;
      seq_en            = 1'b0;
      load_target       = '0;
      // A pending exception may only be replaced by another exception.
      pend_take_new     = (redir_src != SRC_NONE) &&
                          ((pend_src_q != SRC_EXC) || (redir_src == SRC_EXC));

      case (state_q)
         ST_BOOT: state_d = ST_RUN;

         ST_RUN: begin
            if (redir_src != SRC_NONE) begin
               if (fire) begin
`ifdef PCGEN_DELAY_SLOT_EN
                  if (redir_src != SRC_EXC) begin
                     seq_en        = 1'b1;
                     pend_target_d = redir_target;
                     pend_src_d    = redir_src;
                     state_d       = ST_DSLOT;
                  end else begin
                     load_en     = 1'b1;
                     load_target = redir_target;
                  end
`else
                  load_en     = 1'b1;
                  load_target = redir_target;
`endif
               end else begin
                  pend_target_d = redir_target;
                  pend_src_d    = redir_src;
                  state_d       = ST_PEND;
               end
            end else if (fire) begin
               seq_en = 1'b1;
            end
         end

         ST_PEND: begin
            if (pend_take_new) begin
               pend_target_d = redir_target;
               pend_src_d    = redir_src;
            end
            if (fire) begin
               load_en     = 1'b1;
               load_target = pend_take_new ? redir_target : pend_target_q;
               pend_src_d  = SRC_NONE;
               state_d     = ST_RUN;
            end
         end

`ifdef PCGEN_DELAY_SLOT_EN
         ST_DSLOT: begin
            if (redir_src == SRC_EXC) begin
               if (fire) begin
                  load_en     = 1'b1;
                  load_target = redir_target;
                  pend_src_d  = SRC_NONE;
                  state_d     = ST_RUN;
               end else begin
                  pend_target_d = redir_target;
                  pend_src_d    = SRC_EXC;
                  state_d       = ST_PEND;
               end
            end else if (fire) begin
               load_en     = 1'b1;
               load_target = pend_target_q;
               pend_src_d  = SRC_NONE;
               state_d     = ST_RUN;
            end
         end
`endif

         default: state_d = ST_BOOT;
      endcase

      if (load_en) begin
         pc_d              = load_target;
         pc_plus_inc_d     = load_target + INC_X;
         target_misalign_d = |load_target[1:0];
      end else if (seq_en) begin
         pc_d          = pc_plus_inc_q;
         pc_plus_inc_d = pc_plus_inc_q + INC_X;
      end
   end

   // State, PC and pending register; reset also discards any pending redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample together.
      if (!rst_n) begin
         state_q           <= ST_BOOT;
         pc_q              <= RST_PC;
         pc_plus_inc_q     <= RST_PC + INC_X;
         target_misalign_q <= 1'b0;
         // NOTE: the pending slot is reset so a redirect can never survive a reset.
         pend_target_q     <= '0;
         pend_src_q        <= SRC_NONE;
      end else begin
         state_q           <= state_d;
         pc_q              <= pc_d;
         pc_plus_inc_q     <= pc_plus_inc_d;
         target_misalign_q <= target_misalign_d;
         pend_target_q     <= pend_target_d;
         pend_src_q        <= pend_src_d;
      end
   end

   assign bus.pc_valid        = pc_valid;
   assign bus.pc              = pc_q;
   assign bus.pc_plus_inc     = pc_plus_inc_q;
   assign bus.target_misalign = target_misalign_q;
endmodule
